// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and sequencing stage placed in front of the core.
//
// Starting at start_addr, reads 16-bit instructions from a synchronous
// instruction memory, hands each to the core with a one-cycle run pulse, and
// waits for done before moving on. Execution ends at end_addr (inclusive), on a
// stop request (after the current instruction), or on an EXEC timeout.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin execution at start_addr (accepted in IDLE/HALT/ERROR)
//   stop         request halt after the current instruction completes
//   start_addr   first PC, captured when start is accepted
//   end_addr     address of the last instruction (inclusive)
//   mem_rd_en    instruction memory read strobe
//   mem_addr     instruction memory address (always equals pc)
//   mem_rdata    memory read data, valid the cycle after mem_rd_en
//   instruction  registered instruction presented to the core
//   run          one-cycle execute pulse to the core
//   done         core completion (sampled only in EXEC)
//   pc           current program counter
//   busy         high in every state except IDLE, HALT and ERROR
//   halted       high in HALT
//   timeout_err  high in ERROR, sticky until start or reset
module fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    EXEC,
    ADVANCE,
    HALT,
    ERROR
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        stop_latch;
  logic [15:0] exec_cnt;

  assign mem_addr = pc;

  // Outputs are set on the transition into the state they decode, so each
  // one is a flop that is valid for exactly the cycles spent in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      stop_latch  <= 1'b0;
      exec_cnt    <= '0;
      run         <= 1'b0;
      mem_rd_en   <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      run       <= 1'b0;
      mem_rd_en <= 1'b0;

      // busy mirrors the busy states, so it gates the stop request directly.
      if (busy && stop) begin
        stop_latch <= 1'b1;
      end

      case (state)
        IDLE, HALT, ERROR: begin
          if (start) begin
            pc          <= start_addr;
            stop_latch  <= 1'b0;
            state       <= FETCH;
            mem_rd_en   <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
          end
        end

        FETCH: begin
          state <= WAIT_MEM;
        end

        WAIT_MEM: begin
          instruction <= mem_rdata;
          state       <= ISSUE;
          run         <= 1'b1;
        end

        ISSUE: begin
          exec_cnt <= '0;
          state    <= EXEC;
        end

        EXEC: begin
          if (done) begin
            state <= ADVANCE;
          end else if (exec_cnt == CNT_LAST) begin
            state       <= ERROR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt + 16'd1;
          end
        end

        ADVANCE: begin
          if (pc == end_addr) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (stop_latch) begin
            pc     <= pc + ADDR_W'(1);
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            pc        <= pc + ADDR_W'(1);
            state     <= FETCH;
            mem_rd_en <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        done;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic        run;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        timeout_err;

  fetch_unit #(.ADDR_W(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instruction(instruction), .run(run), .done(done), .pc(pc),
    .busy(busy), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory model.
  logic [15:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observations from one program execution.
  logic [15:0] o_instr[$];
  logic [7:0]  o_pc[$];
  int          o_run[$];
  int          o_done[$];
  int          start_cyc, err_cyc;
  bit          hit_halt, hit_err, expired;

  // Reference: addresses that must execute and the pc left behind.
  logic [7:0]  m_addr[$];
  logic [7:0]  m_final;

  function automatic void model(input logic [7:0] sa, input logic [7:0] ea, input int stop_idx);
    logic [7:0] a;
    a = sa;
    m_addr.delete();
    for (int i = 0; i < 300; i++) begin
      m_addr.push_back(a);
      if (a == ea) begin m_final = ea; break; end
      if (i == stop_idx) begin m_final = a + 8'd1; break; end
      a = a + 8'd1;
    end
  endfunction

  // Starts a program and acts as the core: done follows run by lat cycles.
  // stop is pulsed alongside the run of instruction number stop_idx.
  task automatic exec_prog(input logic [7:0] sa, input logic [7:0] ea, input int stop_idx,
                           input int lat, input bit give_done);
    int pending;
    o_instr.delete(); o_pc.delete(); o_run.delete(); o_done.delete();
    hit_halt = 0; hit_err = 0; expired = 1; err_cyc = -1; pending = -1;
    @(negedge clk);
    start_addr = sa; end_addr = ea; start = 1'b1; start_cyc = cyc;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; done = 1'b0;
      if (halted) begin hit_halt = 1; expired = 0; break; end
      if (timeout_err) begin hit_err = 1; err_cyc = cyc; expired = 0; break; end
      if (run) begin
        o_instr.push_back(instruction); o_pc.push_back(pc); o_run.push_back(cyc);
        pending = lat;
        if (o_run.size() - 1 == stop_idx) stop = 1'b1;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          pending = -1;
          if (give_done) begin done = 1'b1; o_done.push_back(cyc); end
        end
      end
    end
    start = 1'b0; stop = 1'b0; done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; stop = 0; done = 0; start_addr = 0; end_addr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({run, mem_rd_en, busy, halted, timeout_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got %b exp 00000", {run, mem_rd_en, busy, halted, timeout_err}); end
    checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if (instruction !== 16'd0) begin failures++; $display("FAIL reset_instr got %h exp 0000", instruction); end
    $display("reset: flags=%b pc=%h instr=%h", {run, mem_rd_en, busy, halted, timeout_err}, pc, instruction);
  endtask

  task automatic test_basic();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    model(8'd0, 8'd2, -1);
    exec_prog(8'd0, 8'd2, -1, 2, 1);
    checks++; if (o_run.size() !== 3) begin failures++; $display("FAIL basic_count got %0d exp 3", o_run.size()); end
    for (int i = 0; i < o_run.size() && i < m_addr.size(); i++) begin
      checks++; if (o_instr[i] !== mem[m_addr[i]]) begin
        failures++; $display("FAIL basic_instr[%0d] got %h exp %h", i, o_instr[i], mem[m_addr[i]]); end
      if (i > 0) begin
        checks++; if (o_run[i] - o_done[i-1] !== 4) begin
          failures++; $display("FAIL basic_done_to_run[%0d] got %0d exp 4", i, o_run[i] - o_done[i-1]); end
      end
      $display("basic: run %0d pc=%h instr=%h", i, o_pc[i], o_instr[i]);
    end
    if (o_run.size() > 0) begin
      checks++; if (o_run[0] - start_cyc !== 3) begin
        failures++; $display("FAIL basic_start_to_run got %0d exp 3", o_run[0] - start_cyc); end
    end
    checks++; if (!hit_halt || pc !== 8'd2 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_end got halt=%0d pc=%h busy=%b exp halt=1 pc=02 busy=0", hit_halt, pc, busy); end
  endtask

  task automatic test_single();
    mem[5] = 16'hA5A5;
    exec_prog(8'd5, 8'd5, -1, 1, 1);
    checks++; if (o_run.size() !== 1) begin failures++; $display("FAIL single_count got %0d exp 1", o_run.size()); end
    if (o_run.size() > 0) begin
      checks++; if (o_instr[0] !== 16'hA5A5) begin failures++; $display("FAIL single_instr got %h exp a5a5", o_instr[0]); end
    end
    checks++; if (!hit_halt || pc !== 8'd5) begin
      failures++; $display("FAIL single_end got halt=%0d pc=%h exp halt=1 pc=05", hit_halt, pc); end
    $display("single: runs=%0d halted=%b pc=%h", o_run.size(), halted, pc);
  endtask

  task automatic test_wrap();
    model(8'hFE, 8'h01, -1);
    exec_prog(8'hFE, 8'h01, -1, 3, 1);
    checks++; if (o_run.size() !== m_addr.size()) begin
      failures++; $display("FAIL wrap_count got %0d exp %0d", o_run.size(), m_addr.size()); end
    for (int i = 0; i < o_run.size() && i < m_addr.size(); i++) begin
      checks++; if (o_pc[i] !== m_addr[i] || o_instr[i] !== mem[m_addr[i]]) begin
        failures++; $display("FAIL wrap_run[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                             i, o_pc[i], o_instr[i], m_addr[i], mem[m_addr[i]]); end
    end
    checks++; if (!hit_halt || pc !== 8'h01) begin
      failures++; $display("FAIL wrap_end got halt=%0d pc=%h exp halt=1 pc=01", hit_halt, pc); end
    $display("wrap: runs=%0d halted=%b pc=%h", o_run.size(), halted, pc);
  endtask

  task automatic test_stop();
    model(8'd0, 8'd9, 3);
    exec_prog(8'd0, 8'd9, 3, 2, 1);
    checks++; if (o_run.size() !== 4) begin failures++; $display("FAIL stop_count got %0d exp 4", o_run.size()); end
    checks++; if (!hit_halt || pc !== m_final) begin
      failures++; $display("FAIL stop_end got halt=%0d pc=%h exp halt=1 pc=%h", hit_halt, pc, m_final); end
    $display("stop: runs=%0d halted=%b pc=%h", o_run.size(), halted, pc);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [7:0] sa, ea;
      int lat, sidx;
      sa = 8'($urandom_range(0, 255));
      ea = sa + 8'($urandom_range(0, 10));
      lat = $urandom_range(1, TO_CYC);
      sidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
      model(sa, ea, sidx);
      exec_prog(sa, ea, sidx, lat, 1);
      checks++; if (o_run.size() !== m_addr.size()) begin
        failures++; $display("FAIL rand%0d_count got %0d exp %0d", k, o_run.size(), m_addr.size()); end
      for (int i = 0; i < o_run.size() && i < m_addr.size(); i++) begin
        checks++; if (o_pc[i] !== m_addr[i] || o_instr[i] !== mem[m_addr[i]]) begin
          failures++; $display("FAIL rand%0d_run[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                               k, i, o_pc[i], o_instr[i], m_addr[i], mem[m_addr[i]]); end
        if (i > 0) begin
          checks++; if (o_run[i] - o_done[i-1] !== 4) begin
            failures++; $display("FAIL rand%0d_gap[%0d] got %0d exp 4", k, i, o_run[i] - o_done[i-1]); end
        end
      end
      checks++; if (!hit_halt || pc !== m_final) begin
        failures++; $display("FAIL rand%0d_end got halt=%0d pc=%h exp halt=1 pc=%h", k, hit_halt, pc, m_final); end
      $display("rand%0d: sa=%h ea=%h lat=%0d stop_idx=%0d runs=%0d pc=%h", k, sa, ea, lat, sidx, o_run.size(), pc);
    end
  endtask

  task automatic test_timeout();
    exec_prog(8'h40, 8'h45, -1, 1, 0);
    checks++; if (!hit_err || o_run.size() !== 1) begin
      failures++; $display("FAIL timeout_hit got err=%0d runs=%0d exp err=1 runs=1", hit_err, o_run.size()); end
    if (hit_err && o_run.size() > 0) begin
      checks++; if (err_cyc - o_run[0] !== TO_CYC + 1) begin
        failures++; $display("FAIL timeout_latency got %0d exp %0d", err_cyc - o_run[0], TO_CYC + 1); end
    end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL timeout_flags got busy=%b halted=%b exp 0 0", busy, halted); end
    $display("timeout: err=%b busy=%b latency=%0d", timeout_err, busy, err_cyc - (o_run.size() > 0 ? o_run[0] : 0));
    exec_prog(8'h20, 8'h20, -1, 2, 1);
    checks++; if (timeout_err !== 1'b0 || !hit_halt) begin
      failures++; $display("FAIL timeout_restart got err=%b halt=%0d exp err=0 halt=1", timeout_err, hit_halt); end
    if (o_run.size() > 0) begin
      checks++; if (o_pc[0] !== 8'h20 || o_instr[0] !== mem[8'h20]) begin
        failures++; $display("FAIL timeout_refetch got pc=%h instr=%h exp pc=20 instr=%h", o_pc[0], o_instr[0], mem[8'h20]); end
    end
    $display("timeout restart: runs=%0d pc=%h", o_run.size(), pc);
  endtask

  task automatic test_async_reset();
    int seen;
    bit got_run;
    mem[3] = 16'hBEEF;
    got_run = 0;
    @(negedge clk);
    start_addr = 8'd3; end_addr = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 20 && !got_run; t++) begin
      if (run) got_run = 1; else @(negedge clk);
    end
    checks++; if (!got_run) begin failures++; $display("FAIL areset_run_wait got no run exp run"); end
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if ({run, busy, mem_rd_en, halted} !== 4'b0) begin
      failures++; $display("FAIL areset_flags got %b exp 0000", {run, busy, mem_rd_en, halted}); end
    checks++; if (pc !== 8'd0 || instruction !== 16'd0) begin
      failures++; $display("FAIL areset_regs got pc=%h instr=%h exp 00 0000", pc, instruction); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (run || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL areset_idle got %0d active cycles exp 0", seen); end
    $display("async reset: pc=%h instr=%h active_after=%0d", pc, instruction, seen);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_stop();
    test_random();
    test_timeout();
    test_async_reset();
    if (expired) begin
      checks++; failures++; $display("FAIL last_program_budget got expired exp completion");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
